// File: rtl/npu_bus_pkg.sv
// Shared encodings for the NPU 15-bit address/data load protocol: regions, op codes,
// region sizes, flat source ROM layout and the host loader state set.
package npu_bus_pkg;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned IDX_W  = 12;
  localparam int unsigned SRC_W  = 11;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RES_W  = 24;

  typedef enum logic [2:0] {
    REG_IMG = 3'b000,
    REG_C1  = 3'b001,
    REG_C2  = 3'b010,
    REG_FC1 = 3'b011,
    REG_FC2 = 3'b100,
    REG_OP  = 3'b101
  } region_e;

  localparam logic [IDX_W-1:0] OP_RST  = 12'd0;
  localparam logic [IDX_W-1:0] OP_TRIG = 12'd1;
  localparam logic [IDX_W-1:0] OP_REQ  = 12'd2;

  localparam int unsigned N_IMG = 240;
  localparam int unsigned N_C1  = 90;
  localparam int unsigned N_C2  = 90;
  localparam int unsigned N_FC1 = 1320;
  localparam int unsigned N_FC2 = 10;

  localparam logic [SRC_W-1:0] BASE_IMG = 11'd0;
  localparam logic [SRC_W-1:0] BASE_C1  = 11'd240;
  localparam logic [SRC_W-1:0] BASE_C2  = 11'd330;
  localparam logic [SRC_W-1:0] BASE_FC1 = 11'd420;
  localparam logic [SRC_W-1:0] BASE_FC2 = 11'd1740;

  typedef enum logic [3:0] {
    StIdle,
    StOpRst,
    StImg,
    StWc1,
    StWc2,
    StWf1,
    StWf2,
    StOpTrig,
    StReq,
    StWaitR,
    StGap
  } loader_state_e;

  function automatic logic [SRC_W-1:0] region_base(input region_e r);
    case (r)
      REG_IMG: return BASE_IMG;
      REG_C1:  return BASE_C1;
      REG_C2:  return BASE_C2;
      REG_FC1: return BASE_FC1;
      REG_FC2: return BASE_FC2;
      default: return '0;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] region_last(input region_e r);
    case (r)
      REG_IMG: return IDX_W'(N_IMG - 1);
      REG_C1:  return IDX_W'(N_C1 - 1);
      REG_C2:  return IDX_W'(N_C2 - 1);
      REG_FC1: return IDX_W'(N_FC1 - 1);
      REG_FC2: return IDX_W'(N_FC2 - 1);
      default: return '0;
    endcase
  endfunction

  // Non-data states map to REG_OP so their ROM base is never used.
  function automatic region_e state_region(input loader_state_e s);
    case (s)
      StImg:   return REG_IMG;
      StWc1:   return REG_C1;
      StWc2:   return REG_C2;
      StWf1:   return REG_FC1;
      StWf2:   return REG_FC2;
      default: return REG_OP;
    endcase
  endfunction

  function automatic loader_state_e next_data_state(input loader_state_e s);
    case (s)
      StImg:   return StWc1;
      StWc1:   return StWc2;
      StWc2:   return StWf1;
      StWf1:   return StWf2;
      default: return StOpTrig;
    endcase
  endfunction

endpackage

// File: rtl/npu_bus_beat.sv
// Single-entry holding register for one NPU bus transaction: loads when empty, holds
// address/data/direction stable until valid&ready, and flags the accept cycle.
module npu_bus_beat
  import npu_bus_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              we_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              we_o,
  output logic              accept_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;

  always_comb begin
    accept_o = valid_q & ready_i;
    valid_d  = valid_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    if (accept_o) begin
      valid_d = 1'b0;
    end
    // A load while a beat is still pending would corrupt it; the owner never does that.
    if (load_i && !valid_q) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      wdata_d = wdata_i;
      we_d    = we_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign we_o    = we_q;

endmodule

// File: rtl/npu_host_loader.sv
// Host-side NPU loader: sends the rst op, streams image and weights from the flat source
// ROM, triggers the NPU, then polls require until done or the poll budget runs out.
module npu_host_loader
  import npu_bus_pkg::*;
#(
  parameter int unsigned POLL_GAP = 8,
  parameter int unsigned MAX_POLL = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [RES_W-1:0]  result,
  output logic              src_rd,
  output logic [SRC_W-1:0]  src_addr,
  input  logic [DATA_W-1:0] src_data,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_rvalid,
  input  logic              bus_rdone,
  input  logic [RES_W-1:0]  bus_rdata
);

  localparam int unsigned PollW = $clog2(MAX_POLL + 1);
  localparam int unsigned GapW  = $clog2(POLL_GAP + 1);

  loader_state_e     state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              fetch_q, fetch_d;
  logic [PollW-1:0]  poll_q, poll_d, poll_inc;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic              timeout_err_q, timeout_err_d;
  logic              timeout_now;

  logic              beat_accept;
  logic [ADDR_W-1:0] beat_addr;
  logic [DATA_W-1:0] beat_wdata;
  logic              beat_we;

  assign poll_inc = poll_q + PollW'(1);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    fetch_d       = 1'b0;
    poll_d        = poll_q;
    gap_d         = gap_q;
    result_d      = result_q;
    timeout_err_d = timeout_err_q;
    timeout_now   = 1'b0;
    src_rd        = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d       = StOpRst;
          fetch_d       = 1'b1;
          poll_d        = '0;
          timeout_err_d = 1'b0;
        end
      end
      StOpRst: begin
        if (beat_accept) begin
          state_d = StImg;
          idx_d   = '0;
          fetch_d = 1'b1;
          src_rd  = 1'b1;
        end
      end
      StImg, StWc1, StWc2, StWf1, StWf2: begin
        // The accept cycle doubles as the ROM fetch cycle of the following beat.
        if (beat_accept) begin
          if (idx_q == region_last(state_region(state_q))) begin
            state_d = next_data_state(state_q);
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
          fetch_d = 1'b1;
          src_rd  = (state_d != StOpTrig);
        end
      end
      StOpTrig: begin
        if (beat_accept) begin
          state_d = StReq;
          fetch_d = 1'b1;
        end
      end
      StReq: begin
        if (beat_accept) begin
          state_d = StWaitR;
        end
      end
      StWaitR: begin
        if (bus_rvalid) begin
          if (bus_rdone) begin
            result_d = bus_rdata;
            done     = 1'b1;
            state_d  = StIdle;
          end else if (poll_inc == PollW'(MAX_POLL)) begin
            poll_d        = poll_inc;
            timeout_err_d = 1'b1;
            timeout_now   = 1'b1;
            done          = 1'b1;
            state_d       = StIdle;
          end else begin
            poll_d  = poll_inc;
            gap_d   = '0;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (gap_q == GapW'(POLL_GAP - 1)) begin
          state_d = StReq;
          fetch_d = 1'b1;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    src_addr = '0;
    if (src_rd) begin
      src_addr = region_base(state_region(state_d)) + SRC_W'(idx_d);
    end
  end

  // Beat contents are loaded one cycle after the fetch, when src_data is valid.
  always_comb begin
    beat_addr  = {state_region(state_q), idx_q};
    beat_wdata = src_data;
    beat_we    = 1'b1;
    case (state_q)
      StOpRst: begin
        beat_addr  = {REG_OP, OP_RST};
        beat_wdata = '0;
      end
      StOpTrig: begin
        beat_addr  = {REG_OP, OP_TRIG};
        beat_wdata = '0;
      end
      StReq: begin
        beat_addr  = {REG_OP, OP_REQ};
        beat_wdata = '0;
        beat_we    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      fetch_q       <= 1'b0;
      poll_q        <= '0;
      gap_q         <= '0;
      result_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      fetch_q       <= fetch_d;
      poll_q        <= poll_d;
      gap_q         <= gap_d;
      result_q      <= result_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  npu_bus_beat u_beat (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (fetch_q),
    .addr_i   (beat_addr),
    .wdata_i  (beat_wdata),
    .we_i     (beat_we),
    .ready_i  (bus_ready),
    .valid_o  (bus_valid),
    .addr_o   (bus_addr),
    .wdata_o  (bus_wdata),
    .we_o     (bus_we),
    .accept_o (beat_accept)
  );

  assign busy        = (state_q != StIdle);
  assign result      = result_q;
  assign timeout_err = timeout_err_q | timeout_now;

endmodule
